// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from EX, waits for its data-SRAM
// response when it is a load, aligns/extends the data and hands the result on to WB.
module mem_stage #(
  parameter int EXREG_LEN  = 158,
  parameter int MEMREG_LEN = 153,
  parameter int BYPASS_LEN = 39
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EX_ready_go,
  input  logic [EXREG_LEN-1:0]  EXreg_bus,
  output logic                  MEM_allow_in,
  output logic                  MEM_ready_go,
  input  logic                  WB_allow_in,
  output logic                  valid,
  output logic [MEMREG_LEN-1:0] MEMreg_bus,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  flush,
  output logic [BYPASS_LEN-1:0] MEM_bypass_bus
);

  typedef struct packed {
    logic        has_sys;
    logic        ertn;
    logic [79:0] csr_ctrl;
    logic        res_from_csr;
    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic        req_issued;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } ex_bus_t;

  // Everything from EX except req_issued, which only steers the state on accept.
  typedef struct packed {
    logic        has_sys;
    logic        ertn;
    logic [79:0] csr_ctrl;
    logic        res_from_csr;
    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } hold_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  ex_bus_t     ex_in;
  hold_t       hold_d;
  hold_t       hold_q;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        mem_valid;
  logic [1:0]  discard_cnt;
  logic [31:0] rdata_buf;

  logic        resp_own;
  logic        accept;
  logic        leave;
  logic        wait_flush;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        load_pending;

  assign ex_in  = EXreg_bus;
  assign hold_d = {ex_in.has_sys, ex_in.ertn, ex_in.csr_ctrl, ex_in.res_from_csr, ex_in.ld_op,
                   ex_in.res_from_mem, ex_in.alu_result, ex_in.rf_we, ex_in.rf_waddr, ex_in.pc};

  // A response belongs to the held load only once all flushed loads' responses have drained.
  assign resp_own     = (state == ST_WAIT) & data_sram_data_ok & (discard_cnt == 2'd0);
  assign MEM_ready_go = (state == ST_DONE) | resp_own;
  assign valid        = mem_valid & MEM_ready_go;
  assign MEM_allow_in = ~mem_valid | (MEM_ready_go & WB_allow_in);
  assign accept       = EX_ready_go & MEM_allow_in & ~flush;
  assign leave        = mem_valid & MEM_ready_go & WB_allow_in;
  assign wait_flush   = flush & (state == ST_WAIT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (flush)         state_nxt = ST_EMPTY;
    else if (accept)   state_nxt = ex_in.req_issued ? ST_WAIT : ST_DONE;
    else if (leave)    state_nxt = ST_EMPTY;
    else if (resp_own) state_nxt = ST_DONE;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: payload and data buffer are reset too, so MEMreg_bus reads all-zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_EMPTY;
      mem_valid   <= 1'b0;
      discard_cnt <= 2'd0;
      rdata_buf   <= 32'd0;
      hold_q      <= '0;
    end else begin
      state <= state_nxt;
      if (flush)       mem_valid <= 1'b0;
      else if (accept) mem_valid <= 1'b1;
      else if (leave)  mem_valid <= 1'b0;
      if (accept) hold_q <= hold_d;
      if (resp_own && !flush) rdata_buf <= data_sram_rdata;
      // A flushed load still owes one response; a same-cycle response cancels the debt.
      if (wait_flush && !data_sram_data_ok) begin
        if (discard_cnt != 2'd3) discard_cnt <= discard_cnt + 2'd1;
      end else if (!wait_flush && data_sram_data_ok && discard_cnt != 2'd0) begin
        discard_cnt <= discard_cnt - 2'd1;
      end
    end
  end

  // In WAIT the response is forwarded combinationally; in DONE it comes from the buffer.
  assign load_word = (state == ST_DONE) ? rdata_buf : data_sram_rdata;
  assign load_half = hold_q.alu_result[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_byte = load_word[7:0];
    case (hold_q.alu_result[1:0])
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      2'd3:    load_byte = load_word[31:24];
      default: load_byte = load_word[7:0];
    endcase
  end

  always_comb begin
    load_data = load_word;
    case (hold_q.ld_op)
      3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b010:  load_data = {{16{load_half[15]}}, load_half};
      3'b011:  load_data = {24'd0, load_byte};
      3'b100:  load_data = {16'd0, load_half};
      default: load_data = load_word;
    endcase
  end

  assign final_result = hold_q.res_from_mem ? load_data : hold_q.alu_result;
  assign load_pending = mem_valid & (state == ST_WAIT) & ~MEM_ready_go;

  assign MEMreg_bus = {hold_q.has_sys, hold_q.ertn, hold_q.csr_ctrl, hold_q.res_from_csr,
                       final_result, hold_q.rf_we, hold_q.rf_waddr, hold_q.pc};

  assign MEM_bypass_bus = {load_pending, hold_q.rf_waddr, hold_q.rf_we & mem_valid, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the held instruction and the outstanding stale responses.
`timescale 1ns/1ps
module tb_mem_stage;

  typedef struct packed {
    logic        has_sys;
    logic        ertn;
    logic [79:0] csr_ctrl;
    logic        res_from_csr;
    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic        req_issued;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } ex_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         EX_ready_go;
  ex_t          ex_bus;
  logic         MEM_allow_in;
  logic         MEM_ready_go;
  logic         WB_allow_in;
  logic         valid;
  logic [152:0] MEMreg_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic [38:0]  MEM_bypass_bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .EX_ready_go      (EX_ready_go),
    .EXreg_bus        (ex_bus),
    .MEM_allow_in     (MEM_allow_in),
    .MEM_ready_go     (MEM_ready_go),
    .WB_allow_in      (WB_allow_in),
    .valid            (valid),
    .MEMreg_bus       (MEMreg_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .flush            (flush),
    .MEM_bypass_bus   (MEM_bypass_bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the one instruction held by the stage, and how many responses still belong to killed loads.
  bit          m_valid;
  ex_t         m_inst;
  bit          m_have;
  logic [31:0] m_data;
  int          m_stale;
  int          pend;
  bit          auto_sram;
  bit          exp_ready;
  bit          exp_allow;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * a));
    h = 16'(d >> (a[1] ? 16 : 0));
    case (op)
      3'd1:    return 32'($signed(b));
      3'd2:    return 32'($signed(h));
      3'd3:    return 32'(b);
      3'd4:    return 32'(h);
      default: return d;
    endcase
  endfunction

  function automatic ex_t rand_inst();
    ex_t e;
    e.has_sys      = 1'($urandom);
    e.ertn         = 1'($urandom);
    e.csr_ctrl     = {16'($urandom), $urandom, $urandom};
    e.res_from_csr = 1'($urandom);
    e.ld_op        = 3'($urandom_range(0, 4));
    e.res_from_mem = 1'($urandom);
    e.req_issued   = e.res_from_mem ? 1'b1 : ($urandom % 4 == 0);
    e.alu_result   = $urandom;
    e.rf_we        = 1'($urandom);
    e.rf_waddr     = 5'($urandom);
    e.pc           = $urandom;
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_have = 0; m_stale = 0; pend = 0; m_data = '0; m_inst = '0;
  endtask

  task automatic check_outputs();
    bit waiting, own, known;
    logic [31:0] res;
    waiting   = m_valid && m_inst.req_issued && !m_have;
    own       = waiting && data_sram_data_ok && (m_stale == 0);
    exp_ready = m_valid && (!m_inst.req_issued || m_have || own);
    exp_allow = !m_valid || (exp_ready && WB_allow_in);
    res = m_inst.res_from_mem
          ? load_value(m_inst.ld_op, m_inst.alu_result[1:0], m_have ? m_data : data_sram_rdata)
          : m_inst.alu_result;
    known = !m_inst.res_from_mem || exp_ready;
    check("allow_in", 160'(MEM_allow_in), 160'(exp_allow));
    check("ready_go", 160'(MEM_ready_go), 160'(exp_ready));
    check("valid", 160'(valid), 160'(exp_ready));
    check("load_pending", 160'(MEM_bypass_bus[38]), 160'(waiting && !own));
    check("bp_we", 160'(MEM_bypass_bus[32]), 160'(m_valid && m_inst.rf_we));
    if (m_valid) begin
      check("bus_ctl", 160'({MEMreg_bus[152:70], MEMreg_bus[37:0]}),
            160'({m_inst.has_sys, m_inst.ertn, m_inst.csr_ctrl, m_inst.res_from_csr,
                  m_inst.rf_we, m_inst.rf_waddr, m_inst.pc}));
      check("bp_waddr", 160'(MEM_bypass_bus[37:33]), 160'(m_inst.rf_waddr));
      if (known) begin
        check("result", 160'(MEMreg_bus[69:38]), 160'(res));
        check("bp_result", 160'(MEM_bypass_bus[31:0]), 160'(res));
      end
    end
  endtask

  task automatic model_update();
    bit waiting;
    waiting = m_valid && m_inst.req_issued && !m_have;
    if (flush) begin
      if (waiting) begin
        if (!data_sram_data_ok && m_stale < 3) m_stale++;
      end else if (data_sram_data_ok && m_stale > 0) begin
        m_stale--;
      end
      m_valid = 0;
      m_have  = 0;
    end else begin
      if (data_sram_data_ok) begin
        if (m_stale > 0) m_stale--;
        else if (waiting) begin m_have = 1; m_data = data_sram_rdata; end
      end
      if (exp_ready && WB_allow_in) m_valid = 0;
      if (EX_ready_go && exp_allow) begin
        m_valid = 1;
        m_inst  = ex_bus;
        m_have  = 0;
        if (auto_sram && ex_bus.req_issued) pend++;
      end
    end
  endtask

  task automatic finish_cycle();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic drive_idle();
    EX_ready_go       = 1'b0;
    ex_bus            = '0;
    WB_allow_in       = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    flush             = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input bit is_load, input logic [31:0] addr);
    ex_t e;
    e = rand_inst();
    e.ld_op        = op;
    e.res_from_mem = is_load;
    e.req_issued   = is_load;
    e.alu_result   = addr;
    ex_bus         = e;
    EX_ready_go    = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    auto_sram = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_allow", 160'(MEM_allow_in), 160'(1));
    check("rst_valid", 160'(valid), 160'(0));
    check("rst_ready_go", 160'(MEM_ready_go), 160'(0));
    check("rst_bus", 160'(MEMreg_bus), 160'(0));
    check("rst_bypass", 160'(MEM_bypass_bus), 160'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ALU op: one-cycle latency, result is alu_result.
    send(3'd0, 0, 32'h1234_5678);
    tick();
    EX_ready_go = 1'b0;
    @(negedge clk);
    check("alu_valid", 160'(valid), 160'(1));
    check("alu_result", 160'(MEMreg_bus[69:38]), 160'(32'h1234_5678));
    finish_cycle();

    // ld.b from byte 3, data two cycles after accept.
    send(3'd1, 1, 32'h1000_0003);
    tick();
    EX_ready_go = 1'b0;
    @(negedge clk);
    check("ldb_pending", 160'(MEM_bypass_bus[38]), 160'(1));
    check("ldb_early_valid", 160'(valid), 160'(0));
    finish_cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_1234;
    @(negedge clk);
    check("ldb_ready_go", 160'(MEM_ready_go), 160'(1));
    check("ldb_result", 160'(MEMreg_bus[69:38]), 160'(32'hFFFF_FF80));
    finish_cycle();
    data_sram_data_ok = 1'b0;

    // ld.hu from halfword 2, then ld.w.
    send(3'd4, 1, 32'h2000_0002);
    tick();
    EX_ready_go       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    @(negedge clk);
    check("ldhu_result", 160'(MEMreg_bus[69:38]), 160'(32'h0000_8001));
    finish_cycle();
    data_sram_data_ok = 1'b0;
    send(3'd0, 1, 32'h3000_0000);
    tick();
    EX_ready_go       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    check("ldw_result", 160'(MEMreg_bus[69:38]), 160'(32'hCAFE_F00D));
    finish_cycle();
    data_sram_data_ok = 1'b0;

    // WB stalled when the response arrives: data must be held in the buffer.
    send(3'd0, 1, 32'h4000_0004);
    tick();
    EX_ready_go       = 1'b0;
    WB_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1357_2468;
    tick();
    data_sram_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_sram_rdata = $urandom;
      @(negedge clk);
      check("stall_valid", 160'(valid), 160'(1));
      check("stall_allow", 160'(MEM_allow_in), 160'(0));
      check("stall_result", 160'(MEMreg_bus[69:38]), 160'(32'h1357_2468));
      finish_cycle();
    end
    WB_allow_in = 1'b1;
    tick();

    // Flush a waiting load; the next load must skip the stale response.
    send(3'd0, 1, 32'h5000_0000);
    tick();
    send(3'd0, 1, 32'h6000_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_allow", 160'(MEM_allow_in), 160'(1));
    finish_cycle();
    EX_ready_go       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stale_valid", 160'(valid), 160'(0));
    check("stale_pending", 160'(MEM_bypass_bus[38]), 160'(1));
    finish_cycle();
    data_sram_data_ok = 1'b0;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0011;
    @(negedge clk);
    check("own_valid", 160'(valid), 160'(1));
    check("own_result", 160'(MEMreg_bus[69:38]), 160'(32'h0000_0011));
    finish_cycle();
    drive_idle();
    tick();

    // Randomized traffic with an in-order SRAM responder.
    auto_sram = 1;
    pend = 0;
    for (int i = 0; i < 3000; i++) begin
      EX_ready_go = ($urandom % 4) != 0;
      ex_bus      = rand_inst();
      WB_allow_in = ($urandom % 4) != 0;
      flush       = ($urandom % 20) == 0;
      if (pend > 0 && ($urandom % 3) == 0) begin
        data_sram_data_ok = 1'b1;
        pend--;
      end else begin
        data_sram_data_ok = 1'b0;
      end
      data_sram_rdata = $urandom;
      tick();
    end
    auto_sram = 0;
    drive_idle();

    // Reset pulse clears the stage before a mid-WAIT test.
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    check("rst2_valid", 160'(valid), 160'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset during WAIT: everything clears and the late response is ignored.
    send(3'd0, 1, 32'h7000_0000);
    tick();
    EX_ready_go = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    check("rstw_valid", 160'(valid), 160'(0));
    check("rstw_allow", 160'(MEM_allow_in), 160'(1));
    check("rstw_pending", 160'(MEM_bypass_bus[38]), 160'(0));
    @(posedge clk);
    #1;
    reset             = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0055;
    @(negedge clk);
    check("late_valid", 160'(valid), 160'(0));
    check("late_ready_go", 160'(MEM_ready_go), 160'(0));
    check("late_allow", 160'(MEM_allow_in), 160'(1));
    finish_cycle();
    data_sram_data_ok = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
